// File: rtl/debug_unit_pkg.sv
// rtl/debug_unit_pkg.sv - command bytes and FSM state encoding for debug_unit
package debug_unit_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] ACK      = 8'h4B;
  localparam logic [7:0] ERR      = 8'hEE;

  typedef enum logic [3:0] {
    IDLE,
    LD_COUNT,
    LD_BYTE,
    LD_WRITE,
    RESP,
    RUN,
    STEP,
    STEP_WAIT,
    D_ADDR,
    D_LATCH,
    D_SEND,
    D_STATUS
  } state_t;

endpackage

// File: rtl/du_word_serializer.sv
// rtl/du_word_serializer.sv - sends a 32-bit word MSB first (or one byte) over valid/ready
module du_word_serializer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_single,
  input  logic [31:0] i_word,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_done
);

  logic [23:0] rest;
  logic [2:0]  left;

  // o_done marks the cycle in which the final byte is accepted
  assign o_done = o_tx_valid && i_tx_ready && (left == 3'd1);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      rest       <= '0;
      left       <= '0;
    end else if (i_start) begin
      o_tx_valid <= 1'b1;
      if (i_single) begin
        o_tx_data <= i_word[7:0];
        rest      <= '0;
        left      <= 3'd1;
      end else begin
        o_tx_data <= i_word[31:24];
        rest      <= i_word[23:0];
        left      <= 3'd4;
      end
    end else if (o_tx_valid && i_tx_ready) begin
      if (left == 3'd1) begin
        o_tx_valid <= 1'b0;
        left       <= '0;
      end else begin
        o_tx_data <= rest[23:16];
        rest      <= {rest[15:0], 8'h00};
        left      <= left - 3'd1;
      end
    end
  end

endmodule

// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART-side debug controller: program load, run/step, register and memory dump
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int NB_REG      = 32,
  parameter int NB_BYTE     = 8,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 32,
  parameter int MAX_INST    = 128
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_reset_pc,
  output logic               o_dunit_w_mem,
  output logic [NB_REG-1:0]  o_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_data,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  input  logic [NB_REG-1:0]  i_dunit_mem_data,
  input  logic               i_halt,
  output logic               o_busy
);

  localparam logic [7:0] N_REGS_B = 8'(N_REGS);
  localparam logic [7:0] LAST_IDX = 8'(N_REGS + N_MEM_WORDS - 1);
  localparam logic [7:0] MAX_B    = 8'(MAX_INST);

  state_t      state, state_nx;
  logic        halted;
  logic [7:0]  ld_cnt, ld_idx, d_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] ld_word;
  logic [NB_REG-1:0] addr_q;
  logic        reset_pc_q;
  logic        ser_start, ser_single, ser_done;
  logic [31:0] ser_word;
  logic [7:0]  ld_idx_nx, d_idx_nx;

  assign ld_idx_nx = 8'(ld_idx + 8'd1);
  assign d_idx_nx  = 8'(d_idx + 8'd1);

  // Dump walks register indices first, then data-memory byte addresses
  function automatic logic [NB_REG-1:0] dump_addr(input logic [7:0] k);
    if (k < N_REGS_B) return NB_REG'(k);
    return NB_REG'({8'(k - N_REGS_B), 2'b00});
  endfunction

  assign o_dunit_clk_en   = ((state == RUN) && !i_halt) || (state == STEP);
  assign o_dunit_reset_pc = reset_pc_q;
  assign o_dunit_w_mem    = (state == LD_WRITE);
  assign o_dunit_addr     = addr_q;
  assign o_dunit_data     = ld_word;
  assign o_busy           = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      halted     <= 1'b0;
      ld_cnt     <= '0;
      ld_idx     <= '0;
      d_idx      <= '0;
      byte_cnt   <= '0;
      ld_word    <= '0;
      addr_q     <= '0;
      reset_pc_q <= 1'b0;
    end else begin
      state      <= state_nx;
      reset_pc_q <= (state == IDLE) && i_rx_valid && (i_rx_data == CMD_LOAD);
      case (state)
        IDLE: if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) halted <= 1'b0;
          if (i_rx_data == CMD_RUN && i_halt) halted <= 1'b1;
          if (i_rx_data == CMD_RUN || i_rx_data == CMD_STEP) begin
            d_idx  <= '0;
            addr_q <= '0;
          end
        end
        LD_COUNT: if (i_rx_valid) begin
          ld_cnt   <= i_rx_data;
          ld_idx   <= '0;
          byte_cnt <= '0;
        end
        LD_BYTE: if (i_rx_valid) begin
          ld_word  <= {ld_word[23:0], i_rx_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) addr_q <= NB_REG'({ld_idx, 2'b00});
        end
        LD_WRITE: begin
          ld_idx   <= ld_idx_nx;
          byte_cnt <= '0;
          // a byte landing during the write cycle starts the next word
          if (i_rx_valid && ld_idx_nx != ld_cnt) begin
            ld_word  <= {ld_word[23:0], i_rx_data};
            byte_cnt <= 2'd1;
          end
        end
        RUN, STEP_WAIT: if (i_halt) halted <= 1'b1;
        D_SEND: if (ser_done && d_idx != LAST_IDX) begin
          d_idx  <= d_idx_nx;
          addr_q <= dump_addr(d_idx_nx);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    ser_start  = 1'b0;
    ser_single = 1'b0;
    ser_word   = '0;
    case (state)
      IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          CMD_LOAD: state_nx = LD_COUNT;
          CMD_RUN:  state_nx = (halted || i_halt) ? D_ADDR : RUN;
          CMD_STEP: state_nx = halted ? D_ADDR : STEP;
          default:  state_nx = IDLE;
        endcase
      end
      LD_COUNT: if (i_rx_valid) begin
        if (i_rx_data == 8'd0 || i_rx_data > MAX_B) begin
          ser_start  = 1'b1;
          ser_single = 1'b1;
          ser_word   = {24'd0, (i_rx_data == 8'd0) ? ACK : ERR};
          state_nx   = RESP;
        end else begin
          state_nx = LD_BYTE;
        end
      end
      LD_BYTE: if (i_rx_valid && byte_cnt == 2'd3) state_nx = LD_WRITE;
      LD_WRITE: begin
        if (ld_idx_nx == ld_cnt) begin
          ser_start  = 1'b1;
          ser_single = 1'b1;
          ser_word   = {24'd0, ACK};
          state_nx   = RESP;
        end else begin
          state_nx = LD_BYTE;
        end
      end
      RESP:      if (ser_done) state_nx = IDLE;
      RUN:       if (i_halt) state_nx = D_ADDR;
      STEP:      state_nx = STEP_WAIT;
      STEP_WAIT: state_nx = D_ADDR;
      D_ADDR:    state_nx = D_LATCH;
      D_LATCH: begin
        ser_start = 1'b1;
        ser_word  = (d_idx < N_REGS_B) ? i_dunit_reg : i_dunit_mem_data;
        state_nx  = D_SEND;
      end
      D_SEND: if (ser_done) state_nx = (d_idx == LAST_IDX) ? D_STATUS : D_ADDR;
      D_STATUS: begin
        ser_start  = 1'b1;
        ser_single = 1'b1;
        ser_word   = {31'd0, halted};
        state_nx   = RESP;
      end
      default: state_nx = IDLE;
    endcase
  end

  du_word_serializer u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (ser_start),
    .i_single   (ser_single),
    .i_word     (ser_word),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (ser_done)
  );

endmodule

// File: tb/tb_debug_unit.sv
// tb/tb_debug_unit.sv - scoreboard bench for debug_unit
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        clk_en, reset_pc, w_mem, busy;
  logic [31:0] addr, wdata, reg_data, mem_data;
  logic        halt = 1'b0;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int wr_cnt = 0;
  int byte_no = 0;
  bit stall_mode = 1'b0;
  logic [7:0] sb[$];

  assign reg_data = 32'h100 + {27'd0, addr[4:0]};
  assign mem_data = 32'hA000 + addr;

  always #5 clk = ~clk;

  debug_unit dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .o_tx_data        (tx_data),
    .o_tx_valid       (tx_valid),
    .i_tx_ready       (tx_ready),
    .o_dunit_clk_en   (clk_en),
    .o_dunit_reset_pc (reset_pc),
    .o_dunit_w_mem    (w_mem),
    .o_dunit_addr     (addr),
    .o_dunit_data     (wdata),
    .i_dunit_reg      (reg_data),
    .i_dunit_mem_data (mem_data),
    .i_halt           (halt),
    .o_busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) sb.push_back(w[i*8 +: 8]);
  endtask

  task automatic push_dump(input logic status);
    for (int k = 0; k < 32; k++) push_word(32'h100 + k);
    for (int m = 0; m < 32; m++) push_word(32'hA000 + 4 * m);
    sb.push_back({7'd0, status});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < budget), 32'd1);
  endtask

  // tx_ready driver: tied high, or high 30% of cycles when stalling
  initial begin
    forever begin
      @(posedge clk); #1;
      tx_ready = stall_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // monitor: counts enables/writes, pops scoreboard on each accepted byte
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp_b;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (clk_en) en_cnt++;
        if (w_mem) wr_cnt++;
        if (prev_stall)
          check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
        if (tx_valid && tx_ready) begin
          check("sb_pending", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            check($sformatf("tx_byte%0d", byte_no), {24'd0, tx_data}, {24'd0, exp_b});
          end
          byte_no++;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] words [2];
    words[0] = 32'h20010005;
    words[1] = 32'hFC000000;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {26'd0, tx_valid, tx_data != 8'h00, clk_en, reset_pc, w_mem, busy}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_data", wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // load two words
    wr_cnt = 0;
    sb.push_back(8'h4B);
    send_byte(8'h4C);
    check("ld_reset_pc", {31'd0, reset_pc}, 32'd1);
    send_byte(8'h02);
    for (int w = 0; w < 2; w++) begin
      for (int b = 3; b >= 0; b--) send_byte(words[w][b*8 +: 8]);
      check($sformatf("ld_wmem%0d", w), {31'd0, w_mem}, 32'd1);
      check($sformatf("ld_addr%0d", w), addr, 32'(4 * w));
      check($sformatf("ld_data%0d", w), wdata, words[w]);
      @(posedge clk); #1;
      check($sformatf("ld_wmem_off%0d", w), {31'd0, w_mem}, 32'd0);
    end
    wait_idle("ld", 200);
    check("ld_writes", wr_cnt, 32'd2);

    // load boundaries: N=0 acks, N=200 errors, neither writes
    wr_cnt = 0;
    sb.push_back(8'h4B);
    send_byte(8'h4C);
    send_byte(8'h00);
    wait_idle("ld0", 200);
    sb.push_back(8'hEE);
    send_byte(8'h4C);
    send_byte(8'hC8);
    wait_idle("ldbig", 200);
    check("ld_bound_writes", wr_cnt, 32'd0);

    // step: one enable cycle, full dump, status 0
    en_cnt  = 0;
    byte_no = 0;
    push_dump(1'b0);
    send_byte(8'h53);
    check("step_en_now", {31'd0, clk_en}, 32'd1);
    wait_idle("step", 3000);
    check("step_en_cnt", en_cnt, 32'd1);
    check("step_bytes", byte_no, 32'd257);

    // run: halt after 10 enable cycles
    en_cnt = 0;
    push_dump(1'b1);
    send_byte(8'h52);
    repeat (10) @(posedge clk);
    #1;
    halt = 1'b1;
    wait_idle("run", 3000);
    check("run_en_cnt", en_cnt, 32'd10);
    halt = 1'b0;

    // run again while halted: immediate dump
    en_cnt = 0;
    push_dump(1'b1);
    send_byte(8'h52);
    check("run2_en_now", {31'd0, clk_en}, 32'd0);
    wait_idle("run2", 3000);
    check("run2_en_cnt", en_cnt, 32'd0);

    // backpressure
    stall_mode = 1'b1;
    byte_no    = 0;
    push_dump(1'b1);
    send_byte(8'h53);
    wait_idle("bp", 8000);
    check("bp_bytes", byte_no, 32'd257);
    stall_mode = 1'b0;

    // asynchronous reset mid-dump
    push_dump(1'b1);
    send_byte(8'h53);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_ctl", {26'd0, tx_valid, tx_data != 8'h00, clk_en, reset_pc, w_mem, busy}, 32'd0);
    check("mid_rst_addr", addr, 32'd0);
    check("mid_rst_data", wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // step after reset: halted cleared
    en_cnt  = 0;
    byte_no = 0;
    push_dump(1'b0);
    send_byte(8'h53);
    check("rst_step_en_now", {31'd0, clk_en}, 32'd1);
    wait_idle("rst_step", 3000);
    check("rst_step_en_cnt", en_cnt, 32'd1);
    check("rst_step_bytes", byte_no, 32'd257);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
